// File: rtl/register_file_pkg.sv
// Shared sizing constants and index types for the 16 x 32-bit register file.
// R15 doubles as the program counter and R14 as the link register.
package register_file_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int PC_IDX   = 15;
    localparam int LR_IDX   = 14;

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [IDX_W-1:0]    reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between the register file and its user: one write port,
// three read ports, and the PC / link-register side channels.
interface register_file_if;
    import register_file_pkg::*;

    word_t    PW;
    reg_idx_t RW;
    logic     load;
    reg_idx_t RA, RB, RC;
    word_t    PA, PB, PC;
    word_t    pc_in;
    logic     pc_enable;
    word_t    pc_plus_4;
    logic     BL_true;
    word_t    pc_out;

    modport master (
        output PW, RW, load, RA, RB, RC, pc_in, pc_enable, pc_plus_4, BL_true,
        input  PA, PB, PC, pc_out
    );

    modport slave (
        input  PW, RW, load, RA, RB, RC, pc_in, pc_enable, pc_plus_4, BL_true,
        output PA, PB, PC, pc_out
    );
endinterface

// File: rtl/register_file_write_decoder.sv
// Turns the write-port index and enable into a one-hot per-register enable.
module rf_write_decoder
    import register_file_pkg::*;
(
    input  reg_idx_t  rw,
    input  logic      load,
    output reg_mask_t en
);
    always_comb begin
        en = '0;
        if (load)
            en[rw] = 1'b1;
    end
endmodule

// File: rtl/register_file.sv
// 16 x 32-bit register file, three combinational read ports, one write port,
// plus dedicated PC (R15) and link (R14) update paths; the write port wins.
module register_file
    import register_file_pkg::*;
(
    input logic             Clk,
    input logic             Reset_n,
    register_file_if.slave  rf
);
    word_t     regs     [NUM_REGS];
    word_t     regs_nxt [NUM_REGS];
    reg_mask_t wr_en;

    rf_write_decoder u_dec (
        .rw   (rf.RW),
        .load (rf.load),
        .en   (wr_en)
    );

    // Priority per register: general write port, then PC/LR side channel, then hold.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = regs[i];
            if (wr_en[i])
                regs_nxt[i] = rf.PW;
            else if (i == PC_IDX && rf.pc_enable)
                regs_nxt[i] = rf.pc_in;
            else if (i == LR_IDX && rf.BL_true)
                regs_nxt[i] = rf.pc_plus_4;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= regs_nxt[i];
        end
    end

    assign rf.PA     = regs[rf.RA];
    assign rf.PB     = regs[rf.RB];
    assign rf.PC     = regs[rf.RC];
    assign rf.pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: hand-computed vectors covering reset,
// write/read ports, PC/LR side channels and write-port priority.
module tb_register_file;
    import register_file_pkg::*;

    logic Clk;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    register_file_if rf_bus ();

    register_file dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .rf      (rf_bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n          = 1'b0;
        rf_bus.PW        = '0;
        rf_bus.RW        = '0;
        rf_bus.load      = 1'b0;
        rf_bus.RA        = 4'd0;
        rf_bus.RB        = 4'd0;
        rf_bus.RC        = 4'd0;
        rf_bus.pc_in     = '0;
        rf_bus.pc_enable = 1'b0;
        rf_bus.pc_plus_4 = '0;
        rf_bus.BL_true   = 1'b0;
        #2;
        check("reset_pa", rf_bus.PA, 32'h0);
        check("reset_pc_out", rf_bus.pc_out, 32'h0);

        // Writes during reset must be ignored.
        rf_bus.load = 1'b1; rf_bus.RW = 4'd1; rf_bus.PW = 32'hDEAD_BEEF;
        rf_bus.pc_enable = 1'b1; rf_bus.pc_in = 32'h1234_5678;
        rf_bus.RA = 4'd1;
        tick();
        check("reset_ignores_load", rf_bus.PA, 32'h0);
        check("reset_ignores_pc", rf_bus.pc_out, 32'h0);
        rf_bus.load = 1'b0; rf_bus.pc_enable = 1'b0;
        Reset_n = 1'b1;

        // Write R1; no bypass before the edge.
        rf_bus.load = 1'b1; rf_bus.RW = 4'd1; rf_bus.PW = 32'h0030_6007; rf_bus.RA = 4'd1;
        #1;
        check("r1_before_edge", rf_bus.PA, 32'h0);
        tick();
        check("r1_after_edge", rf_bus.PA, 32'h0030_6007);

        // R3 and R15 via the write port, pc_enable low.
        rf_bus.RW = 4'd3; rf_bus.PW = 32'h0000_0001;
        tick();
        rf_bus.RW = 4'd15; rf_bus.PW = 32'h02AA_AAAA;
        tick();
        rf_bus.load = 1'b0;
        rf_bus.RC = 4'd3;
        #1;
        check("r3_via_pc_port", rf_bus.PC, 32'h0000_0001);
        rf_bus.RC = 4'd15;
        #1;
        check("r15_via_pc_port", rf_bus.PC, 32'h02AA_AAAA);
        check("pc_out_after_pw", rf_bus.pc_out, 32'h02AA_AAAA);

        // PC load path on successive edges.
        rf_bus.pc_enable = 1'b1; rf_bus.pc_in = 32'h0;
        tick();
        check("pc_load_0", rf_bus.pc_out, 32'h0);
        rf_bus.pc_in = 32'h4;
        tick();
        check("pc_load_4", rf_bus.pc_out, 32'h4);
        rf_bus.RA = 4'd1; rf_bus.RB = 4'd3;
        #1;
        check("r1_held", rf_bus.PA, 32'h0030_6007);
        check("r3_held", rf_bus.PB, 32'h0000_0001);

        // Write port beats pc_in on R15.
        rf_bus.load = 1'b1; rf_bus.RW = 4'd15; rf_bus.PW = 32'hFFFF_0000; rf_bus.pc_in = 32'h10;
        tick();
        check("pw_beats_pc_in", rf_bus.pc_out, 32'hFFFF_0000);
        rf_bus.pc_enable = 1'b0;

        // Write port beats pc_plus_4 on R14.
        rf_bus.BL_true = 1'b1; rf_bus.pc_plus_4 = 32'h8; rf_bus.RW = 4'd14; rf_bus.PW = 32'h0030_6007;
        rf_bus.RA = 4'd14;
        tick();
        check("pw_beats_bl", rf_bus.PA, 32'h0030_6007);

        // BL and write port on different registers both land.
        rf_bus.RW = 4'd2; rf_bus.PW = 32'h3830_6078;
        tick();
        rf_bus.load = 1'b0; rf_bus.BL_true = 1'b0;
        rf_bus.RA = 4'd14; rf_bus.RB = 4'd2;
        #1;
        check("bl_writes_lr", rf_bus.PA, 32'h0000_0008);
        check("pw_writes_r2", rf_bus.PB, 32'h3830_6078);

        // Three ports on the same register agree.
        rf_bus.RA = 4'd2; rf_bus.RB = 4'd2; rf_bus.RC = 4'd2;
        #1;
        check("same_reg_pa", rf_bus.PA, 32'h3830_6078);
        check("same_reg_pb", rf_bus.PB, 32'h3830_6078);
        check("same_reg_pc", rf_bus.PC, 32'h3830_6078);

        // Fill R1..R15 with distinct values.
        rf_bus.load = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            rf_bus.RW = 4'(i);
            rf_bus.PW = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        rf_bus.load = 1'b0;
        rf_bus.RA = 4'd1; rf_bus.RB = 4'd7; rf_bus.RC = 4'd14;
        #1;
        check("fill_r1", rf_bus.PA, 32'hA5A5_0001);
        check("fill_r7", rf_bus.PB, 32'hA5A5_0007);
        check("fill_r14", rf_bus.PC, 32'hA5A5_000E);
        check("fill_r15", rf_bus.pc_out, 32'hA5A5_000F);

        // Async reset mid-cycle with a pending write.
        rf_bus.load = 1'b1; rf_bus.RW = 4'd1; rf_bus.PW = 32'h7777_7777;
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_pa", rf_bus.PA, 32'h0);
        check("async_rst_pb", rf_bus.PB, 32'h0);
        check("async_rst_pc", rf_bus.PC, 32'h0);
        check("async_rst_pc_out", rf_bus.pc_out, 32'h0);
        tick();
        check("pending_discarded", rf_bus.PA, 32'h0);

        // First edge after release performs the write.
        Reset_n = 1'b1;
        tick();
        check("first_write_after_rst", rf_bus.PA, 32'h7777_7777);
        rf_bus.load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters SHALL be none; width is fixed at 32 bits and register count at 16.
REQ-002 Clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Reset_n  input  1  reset; asynchronous and active-low.
REQ-004 PW  input  32  write-port data.
REQ-005 RW  input  4  write-port register index.
REQ-006 load  input  1  write enable for the PW/RW port.
REQ-007 RA, RB, RC  input  4 each  read-port register indices.
REQ-008 PA, PB, PC  output  32 each  read-port data for RA, RB and RC respectively.
REQ-009 pc_in  input  32  next program-counter value.
REQ-010 pc_enable  input  1  enable for loading pc_in into R15.
REQ-011 pc_plus_4  input  32  return address written to R14 on branch-with-link.
REQ-012 BL_true  input  1  branch-with-link strobe; writes pc_plus_4 into R14.
REQ-013 pc_out  output  32  current value of R15.

Function
REQ-014 Storage SHALL be 16 registers R0..R15 of 32 bits each; R15 is the program counter and R14 is the link register.
REQ-015 PA, PB and PC SHALL combinationally reflect R[RA], R[RB] and R[RC]; there is no read latency and no register is hard-wired to zero.
REQ-016 pc_out SHALL combinationally equal R15.
REQ-017 On a rising Clk edge with load=1, R[RW] SHALL take PW.
REQ-018 On a rising Clk edge with pc_enable=1, R15 SHALL take pc_in, unless REQ-020 applies.
REQ-019 On a rising Clk edge with BL_true=1, R14 SHALL take pc_plus_4, unless REQ-021 applies.
REQ-020 If load=1, RW=15 and pc_enable=1 on the same edge, PW SHALL win and pc_in is discarded.
REQ-021 If load=1, RW=14 and BL_true=1 on the same edge, PW SHALL win and pc_plus_4 is discarded.
REQ-022 Writes to different registers on the same edge (PW port, pc_in, pc_plus_4) SHALL all take effect.
REQ-023 There SHALL be no write-to-read bypass; a read of the register being written returns the old value until the edge, then the new value.
REQ-024 Registers not targeted on an edge SHALL hold their value.
REQ-025 Reads from any two or three ports addressing the same register SHALL return identical values.

Reset
REQ-026 Reset_n=0 SHALL asynchronously clear R0..R15 to 0x0000_0000, so PA, PB, PC and pc_out read 0 immediately.
REQ-027 While Reset_n=0, all write inputs SHALL be ignored.
REQ-028 The first write SHALL occur on the first rising Clk edge after Reset_n deasserts; reset asserted mid-operation SHALL discard any pending update.

Structure
REQ-029 A shared package SHALL hold DATA_W=32, NUM_REGS=16, PC_IDX=15 and LR_IDX=14.
REQ-030 One sub-module, rf_write_decoder, SHALL map RW and load to a 16-bit one-hot register enable vector.
REQ-031 Per-register next-value selection (PW, pc_in, pc_plus_4 or hold) and the three 16:1 read multiplexers SHALL reside in register_file.

Verification
REQ-032 Reset then release; load=1, RW=1, PW=0x0030_6007, RA=1 -> after the edge, PA=0x0030_6007; before the edge, PA=0.
REQ-033 Write R3=0x0000_0001 and R15=0x02AA_AAAA (pc_enable=0) -> PC=1 with RC=3; pc_out=0x02AA_AAAA with RC=15.
REQ-034 pc_enable=1, pc_in=0x0000_0000, then pc_in=0x0000_0004, with load=0 -> pc_out reads 0 then 4 on successive edges.
REQ-035 Same edge: load=1, RW=15, PW=0xFFFF_0000, pc_enable=1, pc_in=0x10 -> pc_out=0xFFFF_0000. Same edge: BL_true=1, pc_plus_4=0x8, RW=14, PW=0x0030_6007 -> R14=0x0030_6007.
REQ-036 Same edge: BL_true=1, pc_plus_4=0x8, RW=2, PW=0x3830_6078 -> R14=0x8 and R2=0x3830_6078.
REQ-037 Fill R1..R15 with distinct values, then assert Reset_n=0 between edges -> PA, PB, PC and pc_out are 0 immediately, without waiting for a clock edge.
